// File: rtl/deadtime_gate_driver.sv
// Dead-time gate driver for one half-bridge leg.
// A registered switching request steers a five-state FSM that inserts a fixed dead time
// between turning one gate off and the other on, and enforces a minimum gate on-time.
// Optional feature: define SWITCH_COUNT_EN to build the commutation counter on
// o_switch_count; without it the port is tied to zero and no counter logic exists.
module deadtime_gate_driver #(
    parameter logic [7:0]  DEAD_TIME = 8'd10,  // 1..255 cycles with both gates low
    parameter logic [15:0] MIN_ON    = 16'd20  // 1..65535 cycles minimum on-time
) (
    input  logic        i_clock,
    input  logic        i_RESET,
    input  logic        i_sigma,
    input  logic        i_enable,
    output logic        o_gate_H,
    output logic        o_gate_L,
    output logic        o_dead,
    output logic [15:0] o_switch_count
);

    typedef enum logic [2:0] {
        StIdle,
        StDtH,
        StOnH,
        StDtL,
        StOnL
    } state_e;

    // Terminal counts: transitions fire on the edge where the pre-edge count equals these.
    localparam logic [7:0]  DtLast = DEAD_TIME - 8'd1;
    localparam logic [15:0] OnLast = MIN_ON - 16'd1;

    state_e      state_q, state_d;
    logic        sigma_q, sigma_d;
    logic [7:0]  dt_cnt_q, dt_cnt_d;
    logic [15:0] on_cnt_q, on_cnt_d;
    logic        gate_h_q, gate_h_d;
    logic        gate_l_q, gate_l_d;
    logic        dead_q, dead_d;

    // Next state, counters and registered-output values derived from the next state.
    always_comb begin
        sigma_d  = i_sigma;
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        on_cnt_d = on_cnt_q;

        case (state_q)
            StIdle: begin
                dt_cnt_d = 8'd0;
                on_cnt_d = 16'd0;
                state_d  = sigma_q ? StDtH : StDtL;
            end
            StDtH: begin
                if (!sigma_q) begin
                    // Request reversed mid dead time: restart toward the other side.
                    state_d  = StDtL;
                    dt_cnt_d = 8'd0;
                end else if (dt_cnt_q == DtLast) begin
                    state_d  = StOnH;
                    on_cnt_d = 16'd0;
                end else begin
                    dt_cnt_d = dt_cnt_q + 8'd1;
                end
            end
            StDtL: begin
                if (sigma_q) begin
                    state_d  = StDtH;
                    dt_cnt_d = 8'd0;
                end else if (dt_cnt_q == DtLast) begin
                    state_d  = StOnL;
                    on_cnt_d = 16'd0;
                end else begin
                    dt_cnt_d = dt_cnt_q + 8'd1;
                end
            end
            StOnH: begin
                if (on_cnt_q != 16'hFFFF) begin
                    on_cnt_d = on_cnt_q + 16'd1;
                end
                // sigma_q is a level, so an early reversal simply waits here until MIN_ON.
                if (!sigma_q && (on_cnt_q >= OnLast)) begin
                    state_d  = StDtL;
                    dt_cnt_d = 8'd0;
                end
            end
            StOnL: begin
                if (on_cnt_q != 16'hFFFF) begin
                    on_cnt_d = on_cnt_q + 16'd1;
                end
                if (sigma_q && (on_cnt_q >= OnLast)) begin
                    state_d  = StDtH;
                    dt_cnt_d = 8'd0;
                end
            end
            default: begin
                state_d  = StIdle;
                dt_cnt_d = 8'd0;
                on_cnt_d = 16'd0;
            end
        endcase

        // Disable wins over every transition, including dead-time completion.
        if (!i_enable) begin
            state_d  = StIdle;
            dt_cnt_d = 8'd0;
            on_cnt_d = 16'd0;
        end

        gate_h_d = (state_d == StOnH);
        gate_l_d = (state_d == StOnL);
        dead_d   = (state_d == StDtH) || (state_d == StDtL);
    end

    // State, input sync and output registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            state_q  <= StIdle;
            sigma_q  <= 1'b0;
            dt_cnt_q <= 8'd0;
            on_cnt_q <= 16'd0;
            gate_h_q <= 1'b0;
            gate_l_q <= 1'b0;
            dead_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sigma_q  <= sigma_d;
            dt_cnt_q <= dt_cnt_d;
            on_cnt_q <= on_cnt_d;
            gate_h_q <= gate_h_d;
            gate_l_q <= gate_l_d;
            dead_q   <= dead_d;
        end
    end

    assign o_gate_H = gate_h_q;
    assign o_gate_L = gate_l_q;
    assign o_dead   = dead_q;

`ifdef SWITCH_COUNT_EN
    logic [15:0] sw_cnt_q, sw_cnt_d;
    logic        on_entry;

    // Count entries into an ON state; aborted dead times never reach one, so never count.
    always_comb begin
        on_entry = ((state_d == StOnH) && (state_q != StOnH)) ||
                   ((state_d == StOnL) && (state_q != StOnL));
        sw_cnt_d = on_entry ? (sw_cnt_q + 16'd1) : sw_cnt_q;
    end

    // Commutation counter register; wraps naturally at 16 bits.
    always_ff @(posedge i_clock) begin
        if (i_RESET) begin
            sw_cnt_q <= 16'd0;
        end else begin
            sw_cnt_q <= sw_cnt_d;
        end
    end

    assign o_switch_count = sw_cnt_q;
`else
    assign o_switch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Directed bench for deadtime_gate_driver (DEAD_TIME=10, MIN_ON=20).
// Expected gate/dead/count values are queued per cycle as stimulus is applied and popped
// one per clock edge; a short random phase then checks gate exclusivity.
module tb_deadtime_gate_driver;

    localparam logic [2:0] PH   = 3'b100;  // {gate_H, gate_L, dead}
    localparam logic [2:0] PL   = 3'b010;
    localparam logic [2:0] PD   = 3'b001;
    localparam logic [2:0] PZ   = 3'b000;
    localparam logic [2:0] MALL = 3'b111;
    localparam logic [2:0] MGT  = 3'b110;

    typedef struct {
        string       tag;
        logic [2:0]  val;
        logic [2:0]  msk;
        logic [15:0] cnt;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        sig;
    logic        en;
    logic        gate_h;
    logic        gate_l;
    logic        dead;
    logic [15:0] sw_cnt;

    exp_t        sb_q[$];
    logic [15:0] exp_sw;
    int          n_assert;
    int          n_fail;

    deadtime_gate_driver #(
        .DEAD_TIME(8'd10),
        .MIN_ON   (16'd20)
    ) dut (
        .i_clock       (clk),
        .i_RESET       (rst),
        .i_sigma       (sig),
        .i_enable      (en),
        .o_gate_H      (gate_h),
        .o_gate_L      (gate_l),
        .o_dead        (dead),
        .o_switch_count(sw_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_one();
        exp_t       e;
        logic [2:0] obs;
        e   = sb_q.pop_front();
        obs = {gate_h, gate_l, dead};
        n_assert++;
        assert ((obs & e.msk) === (e.val & e.msk))
        else begin
            n_fail++;
            $error("FAIL %s: H/L/dead observed %b expected %b (mask %b)", e.tag, obs, e.val,
                   e.msk);
        end
        n_assert++;
        assert (sw_cnt === e.cnt)
        else begin
            n_fail++;
            $error("FAIL %s_count: observed %0d expected %0d", e.tag, sw_cnt, e.cnt);
        end
        n_assert++;
        assert (!(gate_h && gate_l))
        else begin
            n_fail++;
            $error("FAIL %s_overlap: observed H=%b L=%b expected never both 1", e.tag, gate_h,
                   gate_l);
        end
    endtask

    // Queue n identical per-cycle expectations, then advance n edges checking each.
    task automatic go(input int n, input string tag, input logic [2:0] val,
                      input logic [2:0] msk);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.val = val;
            e.msk = msk;
`ifdef SWITCH_COUNT_EN
            e.cnt = exp_sw;
`else
            e.cnt = 16'h0000;
`endif
            sb_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_one();
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        exp_sw   = 16'd0;
        rst      = 1'b1;
        en       = 1'b0;
        sig      = 1'b0;
        go(3, "reset", PZ, MALL);

        // Start-up toward the high side; DT_H from edge 2, gate_H at edge 12.
        rst = 1'b0;
        en  = 1'b1;
        sig = 1'b1;
        go(1, "start_e1", PZ, MGT);
        go(10, "start_dt_h", PD, MALL);
        exp_sw++;
        go(1, "start_on_h", PH, MALL);
        go(49, "hold_on_h", PH, MALL);

        // Latency: gate_H drops at edge 2, gate_L rises at edge 12.
        sig = 1'b0;
        go(1, "lat_h_still", PH, MALL);
        go(10, "lat_dt_l", PD, MALL);
        exp_sw++;
        go(1, "lat_on_l", PL, MALL);
        go(29, "hold_on_l", PL, MALL);

        sig = 1'b1;
        go(1, "l2h_l_still", PL, MALL);
        go(10, "l2h_dt_h", PD, MALL);
        exp_sw++;
        go(1, "l2h_on_h", PH, MALL);
        go(5, "early_on_h", PH, MALL);

        // Early reversal is held until 20 on-cycles have elapsed.
        sig = 1'b0;
        go(14, "minon_hold", PH, MALL);
        go(10, "minon_dt_l", PD, MALL);
        exp_sw++;
        go(1, "minon_on_l", PL, MALL);
        go(25, "hold_on_l2", PL, MALL);

        sig = 1'b1;
        go(1, "l2h2_l_still", PL, MALL);
        go(10, "l2h2_dt_h", PD, MALL);
        exp_sw++;
        go(1, "l2h2_on_h", PH, MALL);
        go(25, "hold_on_h2", PH, MALL);

        // Reverse inside DT_L at count 4: restart in DT_H, no gate pulse.
        sig = 1'b0;
        go(1, "abort_h_still", PH, MALL);
        go(4, "abort_dt_l", PD, MALL);
        sig = 1'b1;
        go(11, "abort_dt_h", PD, MALL);
        exp_sw++;
        go(1, "abort_on_h", PH, MALL);
        go(25, "hold_on_h3", PH, MALL);

        sig = 1'b0;
        go(1, "h2l_h_still", PH, MALL);
        go(10, "h2l_dt_l", PD, MALL);
        exp_sw++;
        go(1, "h2l_on_l", PL, MALL);
        go(5, "pre_dis_on_l", PL, MALL);

        // Disable in ON_L clears everything on the next edge.
        en = 1'b0;
        go(3, "dis_on_l", PZ, MALL);
        en = 1'b1;
        go(10, "reen_dt_l", PD, MALL);
        exp_sw++;
        go(1, "reen_on_l", PL, MALL);
        go(25, "hold_on_l3", PL, MALL);

        // Disable lands on the dead-time completion edge and wins.
        sig = 1'b1;
        go(1, "dvd_l_still", PL, MALL);
        go(10, "dvd_dt_h", PD, MALL);
        en = 1'b0;
        go(2, "dis_vs_done", PZ, MALL);

        // Reset mid DT_H with enable still high.
        en = 1'b1;
        go(5, "pre_rst_dt_h", PD, MALL);
        rst    = 1'b1;
        exp_sw = 16'd0;
        go(2, "rst_in_dt_h", PZ, MALL);
        rst = 1'b0;
        en  = 1'b0;
        go(2, "post_rst", PZ, MALL);

        // Three commutations then a dead time aborted by disable.
        en = 1'b1;
        go(10, "c1_dt_h", PD, MALL);
        exp_sw++;
        go(1, "c1_on_h", PH, MALL);
        go(20, "c1_hold", PH, MALL);
        sig = 1'b0;
        go(1, "c2_h_still", PH, MALL);
        go(10, "c2_dt_l", PD, MALL);
        exp_sw++;
        go(1, "c2_on_l", PL, MALL);
        go(20, "c2_hold", PL, MALL);
        sig = 1'b1;
        go(1, "c3_l_still", PL, MALL);
        go(10, "c3_dt_h", PD, MALL);
        exp_sw++;
        go(1, "c3_on_h", PH, MALL);
        go(20, "c3_hold", PH, MALL);
        sig = 1'b0;
        go(1, "c4_h_still", PH, MALL);
        go(3, "c4_dt_l", PD, MALL);
        en = 1'b0;
        go(2, "c4_aborted", PZ, MALL);

        // Random stress: gates never overlap and never coexist with dead.
        for (int i = 0; i < 400; i++) begin
            sig = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 63) == 0);
            @(posedge clk);
            #1;
            n_assert++;
            assert (!(gate_h && gate_l))
            else begin
                n_fail++;
                $error("FAIL stress_overlap: observed H=%b L=%b expected never both 1", gate_h,
                       gate_l);
            end
            n_assert++;
            assert (!(dead && (gate_h || gate_l)))
            else begin
                n_fail++;
                $error("FAIL stress_dead: observed dead=%b H=%b L=%b expected gates 0 in dead",
                       dead, gate_h, gate_l);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
